// File: rtl/tag_lookup_ctrl_if.sv
// Lookup / response / fill / flush bundle between the L1 pipeline and the tag controller.
// The master side drives requests and fills; the slave side is the controller.
interface tag_lookup_ctrl_if #(
    parameter int PA_W  = 35,
    parameter int IDX_W = 7,
    parameter int TAG_W = 22
);
    logic             req_valid;
    logic             req_ready;
    logic [PA_W-1:0]  req_addr;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_hit;
    logic [IDX_W-1:0] resp_index;
    logic [TAG_W:0]   resp_entry;
    logic             fill_valid;
    logic [IDX_W-1:0] fill_index;
    logic [TAG_W-1:0] fill_tag;
    logic             fill_inv;
    logic             flush_req;
    logic             flush_ready;
    logic             init_done;

    modport master (
        output req_valid, req_addr, resp_ready, fill_valid, fill_index, fill_tag, fill_inv, flush_req,
        input  req_ready, resp_valid, resp_hit, resp_index, resp_entry, flush_ready, init_done
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, fill_valid, fill_index, fill_tag, fill_inv, flush_req,
        output req_ready, resp_valid, resp_hit, resp_index, resp_entry, flush_ready, init_done
    );
endinterface

// File: rtl/tag_lookup_ctrl.sv
// Front-end controller for a 128 x {valid,tag} L1 tag RAM: init/flush sweep, lookups with
// hit/miss and backpressure, refill/invalidate writes with same-cycle write-to-read forwarding.
module tag_lookup_ctrl #(
    parameter int PA_W      = 35,
    parameter int LINE_BITS = 6,
    parameter int IDX_W     = 7,
    localparam int TAG_W    = PA_W - IDX_W - LINE_BITS,
    localparam int ENT_W    = TAG_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    tag_lookup_ctrl_if.slave     bus,
    output logic [IDX_W-1:0]     ram_raddr,
    output logic                 ram_re,
    output logic [IDX_W-1:0]     ram_waddr,
    output logic [ENT_W-1:0]     ram_wr,
    output logic                 ram_we,
    input  logic [ENT_W-1:0]     ram_rd
);
    typedef enum logic {SWEEP, RUN} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             resp_valid_q, resp_valid_d;
    logic             fwd_q, fwd_d;
    logic [ENT_W-1:0] fwd_ent_q, fwd_ent_d;

    logic             run, sweep_we, accept, fill_we, flush_go;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [ENT_W-1:0] fill_ent, entry;
    logic             unused_offset;

    assign req_idx       = bus.req_addr[LINE_BITS +: IDX_W];
    assign req_tag       = bus.req_addr[PA_W-1 -: TAG_W];
    assign unused_offset = &{1'b0, bus.req_addr[LINE_BITS-1:0]};

    // Everything handshake-facing is held off while rst is high so no write escapes.
    assign run      = (state_q == RUN) && !rst;
    assign sweep_we = (state_q == SWEEP) && !rst;

    assign bus.req_ready   = run && (!resp_valid_q || bus.resp_ready);
    assign accept          = bus.req_valid && bus.req_ready;
    assign fill_we         = run && bus.fill_valid;
    assign fill_ent        = bus.fill_inv ? '0 : {1'b1, bus.fill_tag};
    assign bus.flush_ready = run && !resp_valid_q && !bus.req_valid;
    assign flush_go        = bus.flush_req && bus.flush_ready;
    assign bus.init_done   = run;

    assign ram_re    = accept;
    assign ram_raddr = req_idx;
    assign ram_we    = sweep_we || fill_we;
    assign ram_waddr = sweep_we ? cnt_q : bus.fill_index;
    assign ram_wr    = sweep_we ? '0 : fill_ent;

    // ram_rd only moves on ram_re, so a stalled response stays stable without a copy.
    assign entry          = fwd_q ? fwd_ent_q : ram_rd;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_index = idx_q;
    assign bus.resp_entry = entry;
    assign bus.resp_hit   = entry[TAG_W] && (entry[TAG_W-1:0] == tag_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        tag_d        = tag_q;
        resp_valid_d = resp_valid_q;
        fwd_d        = fwd_q;
        fwd_ent_d    = fwd_ent_q;
        case (state_q)
            SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = RUN;
            end
            RUN: begin
                if (flush_go) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            default: state_d = SWEEP;
        endcase
        if (accept) begin
            resp_valid_d = 1'b1;
            idx_d        = req_idx;
            tag_d        = req_tag;
            fwd_d        = fill_we && (bus.fill_index == req_idx);
            fwd_ent_d    = fill_ent;
        end else if (bus.resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SWEEP;
            cnt_q        <= '0;
            idx_q        <= '0;
            tag_q        <= '0;
            resp_valid_q <= 1'b0;
            fwd_q        <= 1'b0;
            fwd_ent_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            tag_q        <= tag_d;
            resp_valid_q <= resp_valid_d;
            fwd_q        <= fwd_d;
            fwd_ent_q    <= fwd_ent_d;
        end
    end
endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Bench for tag_lookup_ctrl: tag RAM model, a cycle-level reference of the lookup/fill/sweep
// rules checked every cycle, and directed scenarios with literal expectations.
module tb_tag_lookup_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tag_lookup_ctrl_if bus();
    logic [6:0]  ram_raddr, ram_waddr;
    logic        ram_re, ram_we;
    logic [22:0] ram_wr, ram_rd;

    tag_lookup_ctrl dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_waddr(ram_waddr),
        .ram_wr(ram_wr), .ram_we(ram_we), .ram_rd(ram_rd)
    );

    // Tag RAM: registered read, old data on a same-address write, rd holds when re=0.
    bit [22:0] ram_mem [128];
    bit [22:0] rd_q;
    assign ram_rd = rd_q;
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_waddr] <= ram_wr;
        if (ram_re) rd_q <= ram_mem[ram_raddr];
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [34:0] mk_addr(input logic [21:0] t, input logic [6:0] i);
        return {t, i, 6'b0};
    endfunction

    // Reference: contents the RAM must hold, sweep progress, and the one outstanding response.
    bit        m_sweep = 1'b1;
    int        m_cnt   = 0;
    bit [22:0] m_mem [128];
    bit        m_rv    = 1'b0;
    bit [6:0]  m_ridx;
    bit [21:0] m_rtag;
    bit [22:0] m_rent;
    bit        x_rdy, x_acc, x_fok, x_we;
    bit [6:0]  x_wa, x_ridx;
    bit [22:0] x_wd;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_we", ram_we, 0);
            chk("rst_re", ram_re, 0);
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_flush_ready", bus.flush_ready, 0);
            chk("rst_init_done", bus.init_done, 0);
            m_sweep = 1'b1;
            m_cnt   = 0;
            m_rv    = 1'b0;
        end else begin
            x_ridx = bus.req_addr[12:6];
            x_rdy  = !m_sweep && (!m_rv || bus.resp_ready);
            x_acc  = bus.req_valid && x_rdy;
            x_fok  = !m_sweep && !m_rv && !bus.req_valid;
            chk("req_ready", bus.req_ready, x_rdy);
            chk("flush_ready", bus.flush_ready, x_fok);
            chk("init_done", bus.init_done, !m_sweep);
            chk("ram_re", ram_re, x_acc);
            if (x_acc) chk("ram_raddr", ram_raddr, x_ridx);
            x_we = 1'b0; x_wa = '0; x_wd = '0;
            if (m_sweep) begin
                x_we = 1'b1; x_wa = m_cnt[6:0];
            end else if (bus.fill_valid) begin
                x_we = 1'b1; x_wa = bus.fill_index;
                x_wd = bus.fill_inv ? 23'h0 : {1'b1, bus.fill_tag};
            end
            chk("ram_we", ram_we, x_we);
            if (x_we) begin
                chk("ram_waddr", ram_waddr, x_wa);
                chk("ram_wr", ram_wr, x_wd);
            end
            chk("resp_valid", bus.resp_valid, m_rv);
            if (m_rv) begin
                chk("resp_index", bus.resp_index, m_ridx);
                chk("resp_entry", bus.resp_entry, m_rent);
                chk("resp_hit", bus.resp_hit, m_rent[22] && (m_rent[21:0] == m_rtag));
            end
            // The response sees memory as it stands after this cycle's write.
            if (x_we) m_mem[x_wa] = x_wd;
            if (x_acc) begin
                m_rv = 1'b1; m_ridx = x_ridx; m_rtag = bus.req_addr[34:13]; m_rent = m_mem[x_ridx];
            end else if (bus.resp_ready) begin
                m_rv = 1'b0;
            end
            if (m_sweep) begin
                if (m_cnt == 127) m_sweep = 1'b0;
                m_cnt++;
            end else if (bus.flush_req && x_fok) begin
                m_sweep = 1'b1;
                m_cnt   = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sweep(input string name);
        int n = 0;
        int cyc = 0;
        bit done = 1'b0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (bus.init_done) done = 1'b1;
            else if (ram_we) n++;
        end
        chk({name, "_writes"}, n, 128);
        chk({name, "_init_cycle"}, cyc, 129);
        tick();
    endtask

    task automatic fill(input logic [6:0] i, input logic [21:0] t, input logic inv);
        bus.fill_valid = 1'b1; bus.fill_index = i; bus.fill_tag = t; bus.fill_inv = inv;
        tick();
        bus.fill_valid = 1'b0;
    endtask

    // Any fill the caller has set up goes out in the same cycle as the lookup.
    task automatic lookup(input logic [34:0] a, input logic hit, input logic [22:0] ent, input string name);
        bus.req_valid = 1'b1; bus.req_addr = a;
        tick();
        bus.req_valid = 1'b0; bus.fill_valid = 1'b0;
        @(negedge clk);
        chk({name, "_valid"}, bus.resp_valid, 1);
        chk({name, "_hit"}, bus.resp_hit, hit);
        chk({name, "_entry"}, bus.resp_entry, ent);
        tick();
    endtask

    initial begin
        bus.req_valid = 0; bus.req_addr = '0; bus.resp_ready = 1;
        bus.fill_valid = 0; bus.fill_index = '0; bus.fill_tag = '0; bus.fill_inv = 0;
        bus.flush_req = 0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        wait_sweep("init");

        lookup(mk_addr(22'h1, 7'd1), 1'b0, 23'h0, "miss1");
        fill(7'd1, 22'h1, 1'b0);
        lookup(mk_addr(22'h1, 7'd1), 1'b1, 23'h400001, "hit1");

        bus.fill_valid = 1'b1; bus.fill_index = 7'd5; bus.fill_tag = 22'h3AAAAA; bus.fill_inv = 1'b0;
        lookup(mk_addr(22'h3AAAAA, 7'd5), 1'b1, 23'h7AAAAA, "fwd5");

        // Backpressure: A stalls 4 cycles with B waiting; a fill hits A's index mid-stall.
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_addr = mk_addr(22'h1, 7'd1);
        tick();
        bus.req_addr = mk_addr(22'h3AAAAA, 7'd5);
        bus.fill_valid = 1'b1; bus.fill_index = 7'd1; bus.fill_inv = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stall_entry", bus.resp_entry, 23'h400001);
            chk("stall_index", bus.resp_index, 7'd1);
            chk("stall_req_ready", bus.req_ready, 0);
            chk("stall_ram_re", ram_re, 0);
            tick();
            bus.fill_valid = 1'b0;
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("relA_entry", bus.resp_entry, 23'h400001);
        chk("relA_req_ready", bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("relB_valid", bus.resp_valid, 1);
        chk("relB_index", bus.resp_index, 7'd5);
        chk("relB_entry", bus.resp_entry, 23'h7AAAAA);
        tick();

        fill(7'd9, 22'h123, 1'b0);
        fill(7'd9, 22'h123, 1'b1);
        lookup(mk_addr(22'h123, 7'd9), 1'b0, 23'h0, "inv9");
        fill(7'd9, 22'h123, 1'b0);
        bus.flush_req = 1'b1;
        lookup(mk_addr(22'h123, 7'd9), 1'b1, 23'h400123, "refill9");
        @(negedge clk);
        chk("flush_ready_idle", bus.flush_ready, 1);
        tick();
        bus.flush_req = 1'b0;
        wait_sweep("flush");
        lookup(mk_addr(22'h123, 7'd9), 1'b0, 23'h0, "flushed9");

        // Reset with a stalled response pending, then again mid-sweep.
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_addr = mk_addr(22'h3AAAAA, 7'd5);
        tick();
        bus.req_valid = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (59) tick();
        @(negedge clk);
        chk("cnt59_waddr", ram_waddr, 7'd59);
        chk("cnt59_resp_valid", bus.resp_valid, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.resp_ready = 1'b1;
        wait_sweep("midsweep");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
